debug_ocimem_sequencer: RTL and testbench

- Sysclk-domain controller that owns the on-chip debug RAM (monitor ROM/RAM word array) and shares it between two requesters.
- Requester 1 is the JTAG debug slave action strobes (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo).
- Requester 2 is the CPU-side Avalon debug memory slave.
- Sequences read/write cycles, maintains the monitor address/data registers (MonAReg/MonDReg) with auto-increment, and reports monitor_ready/monitor_error back to the JTAG TCK-side scan chain.

---
 rtl/debug_ocimem_pkg.sv | 28 ++
 rtl/debug_ocimem_rr_arb.sv | 37 +++
 rtl/debug_ocimem_sequencer.sv | 142 ++++++++++++++
 tb/tb_debug_ocimem_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the debug RAM sequencer.
// Latency: n/a. Backpressure: n/a.
package debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AVS_RD  = 2'd1,
        JTAG_RD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } pend_e;

    typedef enum logic {
        GNT_AVS  = 1'b0,
        GNT_JTAG = 1'b1
    } grant_e;

    localparam int JDO_RDREQ   = 35;
    localparam int JDO_ADDR_HI = 25;
    localparam int JDO_ADDR_LO = 18;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;

endpackage

// File: rtl/debug_ocimem_rr_arb.sv
// Two-requester round-robin arbiter (Avalon vs JTAG) with last_grant memory.
// Latency: combinational grant. Backpressure: no grant while en is low.
module debug_ocimem_rr_arb
    import debug_ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req_avs,
    input  logic req_jtag,
    output logic gnt_avs,
    output logic gnt_jtag
);

    grant_e last_grant;

    always_comb begin
        gnt_avs  = 1'b0;
        gnt_jtag = 1'b0;
        if (en) begin
            if (req_avs && req_jtag) begin
                if (last_grant == GNT_AVS) gnt_jtag = 1'b1;
                else                       gnt_avs  = 1'b1;
            end else begin
                gnt_avs  = req_avs;
                gnt_jtag = req_jtag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)      last_grant <= GNT_AVS;
        else if (gnt_avs)  last_grant <= GNT_AVS;
        else if (gnt_jtag) last_grant <= GNT_JTAG;
    end

endmodule

// File: rtl/debug_ocimem_sequencer.sv
// Shares the debug RAM between JTAG monitor strobes and the Avalon debug slave.
// Latency: writes 1 cycle, reads 2 cycles uncontested. Backpressure: avs_waitrequest, JTAG overrun flag.
module debug_ocimem_sequencer
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_e state, state_nxt;
    pend_e  jtag_pend;
    logic   gnt_avs, gnt_jtag;
    logic   jtag_busy, any_strobe, jtag_wr_done;

    // Gating the arbiter with reset_n keeps a reset cycle from issuing RAM writes.
    debug_ocimem_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (reset_n && (state == IDLE)),
        .req_avs  (avs_read | avs_write),
        .req_jtag (jtag_pend != NONE),
        .gnt_avs  (gnt_avs),
        .gnt_jtag (gnt_jtag)
    );

    assign jtag_busy    = (jtag_pend != NONE) || (state == JTAG_RD);
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_wr_done = gnt_jtag && (jtag_pend == WR);

    always_comb begin
        state_nxt       = state;
        ram_addr        = '0;
        ram_wren        = 1'b0;
        ram_byteenable  = '0;
        ram_wdata       = '0;
        avs_waitrequest = 1'b1;
        avs_readdata    = '0;
        case (state)
            IDLE: begin
                if (gnt_avs) begin
                    ram_addr = avs_address;
                    if (avs_read) begin
                        state_nxt = AVS_RD;
                    end else begin
                        ram_wren        = 1'b1;
                        ram_byteenable  = avs_byteenable;
                        ram_wdata       = avs_writedata;
                        avs_waitrequest = 1'b0;
                    end
                end else if (gnt_jtag) begin
                    ram_addr = MonAReg;
                    if (jtag_pend == WR) begin
                        ram_wren       = 1'b1;
                        ram_byteenable = 4'hF;
                        ram_wdata      = MonDReg;
                    end else begin
                        state_nxt = JTAG_RD;
                    end
                end
            end
            AVS_RD: begin
                // No handshake while reset is asserted: the read is abandoned.
                if (reset_n) begin
                    avs_readdata    = ram_rdata;
                    avs_waitrequest = 1'b0;
                end
                state_nxt = IDLE;
            end
            JTAG_RD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            jtag_pend     <= NONE;
        end else begin
            if (jtag_wr_done) begin
                MonAReg       <= MonAReg + ADDR_W'(1);
                monitor_ready <= 1'b1;
                jtag_pend     <= NONE;
            end else if (state == JTAG_RD) begin
                MonDReg       <= ram_rdata;
                MonAReg       <= MonAReg + ADDR_W'(1);
                monitor_ready <= 1'b1;
                jtag_pend     <= NONE;
            end

            // Overrun: strobe dropped, but an address load still takes effect.
            if (any_strobe && jtag_busy) begin
                monitor_error <= 1'b1;
                if (take_action_ocimem_a)
                    MonAReg <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
            end else if (take_action_ocimem_a) begin
                MonAReg       <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
                monitor_error <= 1'b0;
                monitor_ready <= 1'b0;
                if (jdo[JDO_RDREQ]) jtag_pend <= RD;
            end else if (take_action_ocimem_b) begin
                MonDReg       <= DATA_W'(jdo[JDO_DATA_HI:JDO_DATA_LO]);
                jtag_pend     <= WR;
                monitor_ready <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
                jtag_pend     <= RD;
                monitor_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// Scoreboard bench for debug_ocimem_sequencer with a 1-cycle registered RAM model.
module tb_debug_ocimem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    debug_ocimem_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteenable(ram_byteenable),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonAReg(MonAReg), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    function automatic logic [31:0] pat(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // RAM reloads its pattern during reset so the bench owns every word.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!avs_waitrequest && avs_read) begin
            if (rd_q.size() == 0) chk("unexp_avs_rd", {31'b0, !avs_waitrequest}, 32'd0);
            else                  chk("avs_rdata", avs_readdata, rd_q.pop_front());
        end
        if (ram_wren) begin
            if (wr_q.size() == 0) begin
                chk("unexp_ram_wr", {31'b0, ram_wren}, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("ram_addr", {24'b0, ram_addr}, {24'b0, e.a});
                chk("ram_wdata", ram_wdata, e.d);
                chk("ram_be", {28'b0, ram_byteenable}, {28'b0, e.be});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic rd, input logic [7:0] a);
        jdo = '0;
        jdo[35] = rd;
        jdo[25:18] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!monitor_ready && n < 10) begin
            tick();
            n++;
        end
        if (!monitor_ready) chk({tag, "_ready_timeout"}, {31'b0, monitor_ready}, 32'd1);
    endtask

    task automatic avs_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int lat);
        avs_address = a;
        avs_read = !wr;
        avs_write = wr;
        avs_writedata = d;
        avs_byteenable = be;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            lat++;
            if (lat > 20) begin
                chk("avs_timeout", {31'b0, avs_waitrequest}, 32'd0);
                break;
            end
        end
        tick();
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        repeat (3) tick();
        chk("rst_mona", {24'b0, MonAReg}, 32'd0);
        chk("rst_mond", MonDReg, 32'd0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
        chk("rst_error", {31'b0, monitor_error}, 32'd0);
        chk("rst_waitreq", {31'b0, avs_waitrequest}, 32'd1);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_wren", {31'b0, ram_wren}, 32'd0);
        chk("rst_ramaddr", {24'b0, ram_addr}, 32'd0);
        reset_n = 1'b1;
        tick();

        // JTAG address load with read
        strobe_a(1'b1, 8'h10);
        wait_ready("t1");
        chk("t1_mond", MonDReg, 32'hDEADBEEF);
        chk("t1_mona", {24'b0, MonAReg}, 32'h11);

        // JTAG write
        strobe_a(1'b0, 8'h20);
        wr_q.push_back('{a: 8'h20, d: 32'h12345678, be: 4'hF});
        strobe_b(32'h12345678);
        wait_ready("t2");
        chk("t2_mona", {24'b0, MonAReg}, 32'h21);

        // Avalon partial write then readback, and readback of the JTAG write
        wr_q.push_back('{a: 8'h30, d: 32'h11223344, be: 4'b0101});
        avs_xfer(1'b1, 8'h30, 32'h11223344, 4'b0101, lat);
        chk("avs_wr_lat", lat, 32'd0);
        rd_q.push_back((pat(8'h30) & 32'hFF00FF00) | (32'h11223344 & 32'h00FF00FF));
        avs_xfer(1'b0, 8'h30, 32'h0, 4'hF, lat);
        chk("avs_rd_lat", lat, 32'd1);
        rd_q.push_back(32'h12345678);
        avs_xfer(1'b0, 8'h20, 32'h0, 4'hF, lat);

        // Contention: JTAG read pending, last grant was Avalon -> JTAG first
        strobe_a(1'b1, 8'h40);
        rd_q.push_back(pat(8'h05));
        avs_xfer(1'b0, 8'h05, 32'h0, 4'hF, lat);
        chk("t3_contend_lat", lat, 32'd3);
        wait_ready("t3");
        chk("t3_mond", MonDReg, pat(8'h40));
        chk("t3_mona", {24'b0, MonAReg}, 32'h41);

        // Streaming read at top address wraps to 0
        strobe_a(1'b0, 8'hFF);
        tick();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        wait_ready("t4");
        chk("t4_mond", MonDReg, pat(8'hFF));
        chk("t4_mona_wrap", {24'b0, MonAReg}, 32'h00);
        chk("t4_no_error", {31'b0, monitor_error}, 32'd0);

        // Overrun: second write strobe during the grant cycle is dropped
        strobe_a(1'b0, 8'h50);
        wr_q.push_back('{a: 8'h50, d: 32'h11111111, be: 4'hF});
        strobe_b(32'h11111111);
        strobe_b(32'h22222222);
        wait_ready("t5");
        repeat (3) tick();
        chk("t5_error", {31'b0, monitor_error}, 32'd1);
        chk("t5_mona", {24'b0, MonAReg}, 32'h51);
        chk("t5_mond", MonDReg, 32'h11111111);
        strobe_a(1'b0, 8'h60);
        chk("t5_error_clr", {31'b0, monitor_error}, 32'd0);
        chk("t5_mona_reload", {24'b0, MonAReg}, 32'h60);

        // Reset in the middle of an Avalon read
        avs_address = 8'h07;
        avs_read = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        avs_read = 1'b0;
        chk("t6_waitreq", {31'b0, avs_waitrequest}, 32'd1);
        chk("t6_mona", {24'b0, MonAReg}, 32'd0);
        chk("t6_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t6_idle_waitreq", {31'b0, avs_waitrequest}, 32'd1);

        chk("rd_q_empty", rd_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
